txn_fragmenter: RTL and testbench



---
 rtl/txn_fragmenter_if.sv | 46 ++++
 rtl/txn_fragmenter.sv | 172 +++++++++++++++++
 tb/tb_txn_fragmenter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/txn_fragmenter_if.sv
// Request and transaction streams of the fragmenter.
// The slave modport is the fragmenter's view; the master modport drives it.
interface txn_fragmenter_if #(
  parameter int AddrWidth   = 64,
  parameter int LenWidth    = 16,
  parameter int SegCntWidth = 8,
  parameter int BoundBits   = 13,
  parameter int IdWidth     = 4
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [IdWidth-1:0]     req_id_i;
  logic [AddrWidth-1:0]   req_addr_i;
  logic [LenWidth-1:0]    req_seg_nbs_i;
  logic [SegCntWidth-1:0] req_nr_seg_i;
  logic [AddrWidth-1:0]   req_stride_i;
  logic                   req_is_load_i;
  logic                   stall_i;
  logic                   meta_enq_valid_o;
  logic                   txn_valid_o;
  logic                   txn_ready_i;
  logic [AddrWidth-1:0]   txn_addr_o;
  logic [BoundBits:0]     txn_nbs_o;
  logic [IdWidth-1:0]     txn_id_o;
  logic                   txn_is_load_o;
  logic                   txn_seg_first_o;
  logic                   txn_seg_last_o;
  logic                   txn_req_last_o;
  logic                   busy_o;

  modport master (
    output req_valid_i, req_id_i, req_addr_i, req_seg_nbs_i, req_nr_seg_i,
           req_stride_i, req_is_load_i, stall_i, txn_ready_i,
    input  req_ready_o, meta_enq_valid_o, txn_valid_o, txn_addr_o, txn_nbs_o,
           txn_id_o, txn_is_load_o, txn_seg_first_o, txn_seg_last_o,
           txn_req_last_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_id_i, req_addr_i, req_seg_nbs_i, req_nr_seg_i,
           req_stride_i, req_is_load_i, stall_i, txn_ready_i,
    output req_ready_o, meta_enq_valid_o, txn_valid_o, txn_addr_o, txn_nbs_o,
           txn_id_o, txn_is_load_o, txn_seg_first_o, txn_seg_last_o,
           txn_req_last_o, busy_o
  );
endinterface

// File: rtl/txn_fragmenter.sv
// Splits queued segmented requests into bus transactions that never cross a
// 2^BoundBits-nibble boundary, one per cycle on a valid/ready stream.
module txn_fragmenter #(
  parameter int AddrWidth   = 64,
  parameter int LenWidth    = 16,
  parameter int SegCntWidth = 8,
  parameter int BoundBits   = 13,
  parameter int ReqDepth    = 2,
  parameter int IdWidth     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  txn_fragmenter_if.slave  bus
);
  localparam int PtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int CntW = $clog2(ReqDepth + 1);
  localparam int CmpW = LenWidth + 1;
  localparam logic [CmpW-1:0] BoundNbs = CmpW'(1) << BoundBits;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [LenWidth-1:0]    seg_nbs;
    logic [SegCntWidth-1:0] nr_seg;
    logic [AddrWidth-1:0]   stride;
    logic                   is_load;
  } req_t;

  typedef enum logic [1:0] {IDLE, INIT, STALL, FRAG} state_t;

  req_t                          r_fifo [ReqDepth];
  logic [PtrW-1:0]               r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]               r_count;
  state_t                        r_state;
  logic                          r_meta;
  logic [IdWidth-1:0]            r_id;
  logic                          r_is_load;
  logic [AddrWidth-1:0]          r_seg_base;
  logic [AddrWidth-1:0]          r_addr;
  logic [LenWidth-1:0]           r_seg_nbs;
  logic [LenWidth-1:0]           r_rem;
  logic [SegCntWidth-1:0]        r_seg_cnt;
  logic signed [AddrWidth-1:0]   r_stride;
  logic                          r_first;

  req_t                 w_in, w_head;
  logic                 w_push, w_pop, w_empty, w_full, w_frag;
  logic [CmpW-1:0]      w_room, w_rem, w_nbs;
  logic                 w_seg_last, w_req_last;
  logic [AddrWidth-1:0] w_next_base;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(ReqDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_in = '{id: bus.req_id_i, addr: bus.req_addr_i, seg_nbs: bus.req_seg_nbs_i,
                  nr_seg: bus.req_nr_seg_i, stride: bus.req_stride_i,
                  is_load: bus.req_is_load_i};
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(ReqDepth));
  assign w_push  = bus.req_valid_i && !w_full;

  // Boundary split uses only the low BoundBits of the address
  assign w_room      = BoundNbs - {{(CmpW-BoundBits){1'b0}}, r_addr[BoundBits-1:0]};
  assign w_rem       = {1'b0, r_rem};
  assign w_nbs       = (w_rem < w_room) ? w_rem : w_room;
  assign w_seg_last  = (w_nbs == w_rem);
  assign w_req_last  = w_seg_last && (r_seg_cnt == '0);
  assign w_next_base = r_seg_base + r_stride;
  assign w_frag      = (r_state == FRAG);

  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || (w_frag && bus.txn_ready_i && w_req_last));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_meta     <= 1'b0;
      r_id       <= '0;
      r_is_load  <= 1'b0;
      r_seg_base <= '0;
      r_addr     <= '0;
      r_seg_nbs  <= '0;
      r_rem      <= '0;
      r_seg_cnt  <= '0;
      r_stride   <= '0;
      r_first    <= 1'b0;
    end else begin
      r_meta <= 1'b0;
      case (r_state)
        IDLE: if (!w_empty) r_state <= INIT;
        INIT: begin
          if (r_seg_nbs == '0) begin
            r_state <= IDLE;
          end else begin
            r_rem   <= r_seg_nbs;
            r_addr  <= r_seg_base;
            r_first <= 1'b1;
            if (bus.stall_i) begin
              r_state <= STALL;
            end else begin
              r_state <= FRAG;
              r_meta  <= 1'b1;
            end
          end
        end
        STALL: begin
          if (!bus.stall_i) begin
            r_state <= FRAG;
            r_meta  <= 1'b1;
          end
        end
        FRAG: begin
          if (bus.txn_ready_i) begin
            r_first <= 1'b0;
            r_addr  <= r_addr + AddrWidth'(w_nbs);
            r_rem   <= r_rem - w_nbs[LenWidth-1:0];
            if (w_req_last) begin
              r_state <= w_empty ? IDLE : INIT;
            end else if (w_seg_last) begin
              r_seg_base <= w_next_base;
              r_addr     <= w_next_base;
              r_rem      <= r_seg_nbs;
              r_seg_cnt  <= r_seg_cnt - 1'b1;
              r_first    <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // A pop overrides the working registers with the next request
      if (w_pop) begin
        r_id       <= w_head.id;
        r_is_load  <= w_head.is_load;
        r_seg_base <= w_head.addr;
        r_addr     <= w_head.addr;
        r_seg_nbs  <= w_head.seg_nbs;
        r_seg_cnt  <= w_head.nr_seg;
        r_stride   <= w_head.stride;
      end
    end
  end

  assign bus.req_ready_o      = !w_full;
  assign bus.meta_enq_valid_o = r_meta;
  assign bus.txn_valid_o      = w_frag;
  assign bus.txn_addr_o       = w_frag ? r_addr : '0;
  assign bus.txn_nbs_o        = w_frag ? w_nbs[BoundBits:0] : '0;
  assign bus.txn_id_o         = w_frag ? r_id : '0;
  assign bus.txn_is_load_o    = w_frag && r_is_load;
  assign bus.txn_seg_first_o  = w_frag && r_first;
  assign bus.txn_seg_last_o   = w_frag && w_seg_last;
  assign bus.txn_req_last_o   = w_frag && w_req_last;
  assign bus.busy_o           = !w_empty || (r_state != IDLE);
endmodule

// File: tb/tb_txn_fragmenter.sv
// Scoreboard bench for txn_fragmenter: expected transactions are queued when a
// request is accepted and compared in order as the DUT hands them over.
module tb_txn_fragmenter;
  localparam int AW = 64, LW = 16, SW = 8, BB = 13, RD = 2, IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  txn_fragmenter_if #(.AddrWidth(AW), .LenWidth(LW), .SegCntWidth(SW),
                      .BoundBits(BB), .IdWidth(IW)) bus ();

  txn_fragmenter #(.AddrWidth(AW), .LenWidth(LW), .SegCntWidth(SW),
                   .BoundBits(BB), .ReqDepth(RD), .IdWidth(IW))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [63:0] addr;
    int          nbs;
    logic [3:0]  id;
    logic        ld, first, last, rlast;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   n_vec = 0, n_err = 0;
  int   n_meta = 0, n_meta_exp = 0;
  int   cyc = 0;
  bit   rnd_rdy = 0;
  logic prev_meta = 1'b0;
  logic hold_pend = 1'b0;
  exp_t held, e_mon;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [63:0] a, input int n, input logic [3:0] id,
                          input logic ld, input logic f, input logic l, input logic rl);
    exp_t e;
    e.addr = a; e.nbs = n; e.id = id; e.ld = ld; e.first = f; e.last = l; e.rlast = rl;
    sb.push_back(e);
  endtask

  task automatic model_req(input logic [3:0] id, input logic [63:0] a, input int n,
                           input int nr, input logic [63:0] st, input logic ld);
    logic [63:0] base, cur;
    int rem, room, t;
    bit first;
    base = a;
    for (int s = 0; s <= nr; s++) begin
      cur = base; rem = n; first = 1;
      while (rem > 0) begin
        room = 8192 - int'(cur[12:0]);
        t = (rem < room) ? rem : room;
        exp_push(cur, t, id, ld, first, t == rem, (t == rem) && (s == nr));
        cur = cur + 64'(t); rem = rem - t; first = 0;
      end
      base = base + st;
    end
  endtask

  // Starts and ends just after a rising edge
  task automatic push_req(input logic [3:0] id, input logic [63:0] a, input int n,
                          input int nr, input logic [63:0] st, input logic ld,
                          input bit use_model);
    int i;
    bus.req_valid_i   = 1'b1;
    bus.req_id_i      = id;
    bus.req_addr_i    = a;
    bus.req_seg_nbs_i = 16'(n);
    bus.req_nr_seg_i  = 8'(nr);
    bus.req_stride_i  = st;
    bus.req_is_load_i = ld;
    i = 0;
    do begin @(negedge clk); i++; end while (!bus.req_ready_o && i < 500);
    if (!bus.req_ready_o) chk("req_accept", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    if (n != 0) n_meta_exp++;
    if (use_model) model_req(id, a, n, nr, st, ld);
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while ((sb.size() != 0 || bus.busy_o) && i < 3000) begin
      @(posedge clk); #1; i++;
    end
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (!bus.txn_valid_o && i < 50);
    chk({tag, "_valid"}, 64'(bus.txn_valid_o), 64'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 bus.txn_ready_i = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      prev_meta = 1'b0;
    end else begin
      if (bus.meta_enq_valid_o) begin
        n_meta++;
        chk("meta_one_cycle", 64'(prev_meta), 64'd0);
      end
      prev_meta = bus.meta_enq_valid_o;
      if (hold_pend) begin
        chk("hold_valid", 64'(bus.txn_valid_o), 64'd1);
        chk("hold_addr", bus.txn_addr_o, held.addr);
        chk("hold_nbs", 64'(bus.txn_nbs_o), 64'(held.nbs));
      end
      if (bus.txn_valid_o && bus.txn_ready_i) begin
        hs_cyc.push_back(cyc);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e_mon = sb.pop_front();
          chk("txn_addr", bus.txn_addr_o, e_mon.addr);
          chk("txn_nbs", 64'(bus.txn_nbs_o), 64'(e_mon.nbs));
          chk("txn_id", 64'(bus.txn_id_o), 64'(e_mon.id));
          chk("txn_load", 64'(bus.txn_is_load_o), 64'(e_mon.ld));
          chk("txn_first", 64'(bus.txn_seg_first_o), 64'(e_mon.first));
          chk("txn_last", 64'(bus.txn_seg_last_o), 64'(e_mon.last));
          chk("txn_rlast", 64'(bus.txn_req_last_o), 64'(e_mon.rlast));
        end
      end
      hold_pend = bus.txn_valid_o && !bus.txn_ready_i;
      held.addr = bus.txn_addr_o;
      held.nbs  = int'(bus.txn_nbs_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, d;
    logic [63:0] ra, rs;
    bus.req_valid_i = 0; bus.req_id_i = 0; bus.req_addr_i = 0; bus.req_seg_nbs_i = 0;
    bus.req_nr_seg_i = 0; bus.req_stride_i = 0; bus.req_is_load_i = 0;
    bus.stall_i = 0; bus.txn_ready_i = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_txn_valid", 64'(bus.txn_valid_o), 64'd0);
    chk("rst_meta", 64'(bus.meta_enq_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_addr", bus.txn_addr_o, 64'd0);
    chk("rst_nbs", 64'(bus.txn_nbs_o), 64'd0);
    chk("rst_flags", 64'({bus.txn_seg_first_o, bus.txn_seg_last_o, bus.txn_req_last_o}), 64'd0);
    rst = 0;
    @(posedge clk); #1;

    // Boundary split
    bus.txn_ready_i = 1;
    hs_cyc.delete(); m0 = n_meta;
    exp_push(64'h1F00, 'h100, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_push(64'h2000, 'h200, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    push_req(4'd1, 64'h1F00, 'h300, 0, 64'd0, 1'b1, 0);
    wait_drain("split");
    d = (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1;
    chk("split_b2b", 64'(d), 64'd1);
    chk("split_meta", 64'(n_meta - m0), 64'd1);

    // Positive stride, throughput across segments
    hs_cyc.delete();
    exp_push(64'h0000, 4, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_push(64'h2000, 4, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_push(64'h4000, 4, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    push_req(4'd2, 64'h0, 4, 2, 64'h2000, 1'b0, 0);
    wait_drain("pstride");
    d = (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[0] : -1;
    chk("pstride_b2b", 64'(d), 64'd2);

    // Negative stride with address wrap
    exp_push(64'h10, 8, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_push(64'hFFFF_FFFF_FFFF_FFF0, 8, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    push_req(4'd3, 64'h10, 8, 1, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1, 0);
    wait_drain("nstride");

    // Stall held from INIT, then toggled inside FRAG
    bus.txn_ready_i = 0; bus.stall_i = 1; m0 = n_meta;
    exp_push(64'h40, 4, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1);
    push_req(4'd4, 64'h40, 4, 0, 64'd0, 1'b0, 0);
    repeat (6) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.txn_valid_o), 64'd0);
      chk("stall_meta", 64'(bus.meta_enq_valid_o), 64'd0);
    end
    @(posedge clk); #1;
    bus.stall_i = 0;
    wait_valid("stall");
    chk("stall_meta_first", 64'(bus.meta_enq_valid_o), 64'd1);
    repeat (4) begin @(posedge clk); #1; bus.stall_i = ~bus.stall_i; end
    @(negedge clk);
    chk("frag_stall_ignored", 64'(bus.txn_valid_o), 64'd1);
    @(posedge clk); #1;
    bus.stall_i = 0; bus.txn_ready_i = 1;
    wait_drain("stall");
    chk("stall_meta_count", 64'(n_meta - m0), 64'd1);

    // Queue depth with a zero-length request in the middle
    bus.txn_ready_i = 0;
    push_req(4'd5, 64'h1FFC, 8, 1, 64'h10, 1'b1, 1);
    push_req(4'd6, 64'h500, 0, 0, 64'd0, 1'b0, 1);
    push_req(4'd7, 64'h100, 'h10, 0, 64'd0, 1'b0, 1);
    @(negedge clk);
    chk("queue_full_ready", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk); #1;
    hs_cyc.delete();
    fork
      begin repeat (3) @(posedge clk); #1 bus.txn_ready_i = 1; end
    join_none
    push_req(4'd8, 64'h300, 4, 0, 64'd0, 1'b1, 1);
    wait_drain("queue");
    d = (hs_cyc.size() >= 5) ? hs_cyc[4] - hs_cyc[3] : -1;
    chk("queue_init_bubble", 64'(d), 64'd2);

    // Reset during the second of four transactions
    bus.txn_ready_i = 0;
    push_req(4'd9, 64'h0, 4, 3, 64'h100, 1'b0, 1);
    wait_valid("rstmid");
    @(posedge clk); #1; bus.txn_ready_i = 1;
    @(posedge clk); #1; bus.txn_ready_i = 0; rst = 1;
    @(posedge clk); #1;
    chk("rstmid_valid", 64'(bus.txn_valid_o), 64'd0);
    chk("rstmid_busy", 64'(bus.busy_o), 64'd0);
    chk("rstmid_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rstmid_sb_left", 64'(sb.size()), 64'd3);
    sb.delete();
    rst = 0;
    @(posedge clk); #1;
    bus.txn_ready_i = 1;
    push_req(4'd10, 64'h1FF0, 'h20, 0, 64'd0, 1'b1, 1);
    wait_drain("after_rst");

    // Random requests under random backpressure
    rnd_rdy = 1;
    for (int k = 0; k < 10; k++) begin
      ra = {32'($urandom), 32'($urandom)};
      rs = {32'($urandom), 32'($urandom)};
      push_req(4'(k), ra, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 'h2400)),
               int'($urandom_range(0, 3)), rs, 1'($urandom_range(0, 1)), 1);
    end
    rnd_rdy = 0;
    @(posedge clk); #2;
    bus.txn_ready_i = 1;
    wait_drain("random");

    chk("meta_total", 64'(n_meta), 64'(n_meta_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
